// File: rtl/pipeline_stage_buf_if.sv
// pipeline_stage_buf_if: handshake and bundle signals of one inter-stage pipeline register.
// Upstream side: in_valid, in_ready, in_ctrl, in_data, flush.
// Downstream side: out_valid, out_ready, out_ctrl, out_data, plus the stall_cnt status.
// The slave modport is the buffer's own view. The master modport is the view of the logic driving it.
interface pipeline_stage_buf_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 101,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  in_valid, in_ctrl, in_data, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, stall_cnt
    );

    modport master (
        output in_valid, in_ctrl, in_data, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
    );
endinterface

// File: rtl/pipeline_stage_buf.sv
// pipeline_stage_buf: generic valid/ready pipeline register with optional 2-entry skid, flush and ctrl bubble gating.
// Ports:
//   clk     rising-edge clock
//   reset_n asynchronous active-low reset
//   bus     pipeline_stage_buf_if.slave
//           in_valid/in_ready/in_ctrl/in_data/flush: upstream side
//           out_valid/out_ready/out_ctrl/out_data: downstream side
//           stall_cnt: saturating count of out_valid & !out_ready cycles
module pipeline_stage_buf #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 101,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    pipeline_stage_buf_if.slave bus
);
    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              accept, drain, load_from_skid, load_from_in;

    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = main_valid_q & bus.out_ready;

    // A flush blocks every load, so an entry offered in the flush cycle is dropped.
    // Main takes the new entry only when it is empty, or when it drains with nothing waiting in skid.
    always_comb begin
        load_from_skid = !bus.flush & drain & skid_valid_q;
        load_from_in   = !bus.flush & accept & (!main_valid_q | (drain & !skid_valid_q));
        main_valid_d   = bus.flush ? 1'b0 :
                         (load_from_skid | load_from_in) ? 1'b1 :
                         drain ? 1'b0 : main_valid_q;
        main_ctrl_d    = load_from_skid ? skid_ctrl_q : load_from_in ? bus.in_ctrl : main_ctrl_q;
        main_data_d    = load_from_skid ? skid_data_q : load_from_in ? bus.in_data : main_data_q;
        stall_d        = (main_valid_q & !bus.out_ready & (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= '0;
            main_data_q  <= '0;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
            stall_q      <= stall_d;
        end
    end

    if (SKID != 0) begin : g_skid
        logic              load_skid, skid_valid_d;
        logic [CTRL_W-1:0] skid_ctrl_d;
        logic [DATA_W-1:0] skid_data_d;
        logic              sv_q;
        logic [CTRL_W-1:0] sc_q;
        logic [DATA_W-1:0] sd_q;
        // Skid catches an accept that main cannot take: main is held, or main is being refilled from skid.
        always_comb begin
            load_skid    = !bus.flush & accept & main_valid_q & (!drain | sv_q);
            skid_valid_d = bus.flush ? 1'b0 : load_skid ? 1'b1 : drain ? 1'b0 : sv_q;
            skid_ctrl_d  = load_skid ? bus.in_ctrl : sc_q;
            skid_data_d  = load_skid ? bus.in_data : sd_q;
        end
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sv_q <= 1'b0;
                sc_q <= '0;
                sd_q <= '0;
            end else begin
                sv_q <= skid_valid_d;
                sc_q <= skid_ctrl_d;
                sd_q <= skid_data_d;
            end
        end
        assign skid_valid_q = sv_q;
        assign skid_ctrl_q  = sc_q;
        assign skid_data_q  = sd_q;
        // in_ready comes straight from a flop, so out_ready has no combinational path to upstream.
        assign bus.in_ready = !sv_q;
    end else begin : g_noskid
        assign skid_valid_q = 1'b0;
        assign skid_ctrl_q  = '0;
        assign skid_data_q  = '0;
        assign bus.in_ready = bus.out_ready | !main_valid_q;
    end

    assign bus.out_valid = main_valid_q;
    assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};
    assign bus.out_data  = main_data_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_pipeline_stage_buf.sv
// tb_pipeline_stage_buf: checks three pipeline_stage_buf variants (skid, no skid, 4-bit counter) against a FIFO model.
module tb_pipeline_stage_buf;
    logic clk, reset_n;
    logic s_iv, s_fl, s_or;
    logic [7:0] s_ic;
    logic [100:0] s_id;

    pipeline_stage_buf_if #(.CTRL_W(8), .DATA_W(101), .CNT_W(16)) b0 ();
    pipeline_stage_buf_if #(.CTRL_W(8), .DATA_W(101), .CNT_W(16)) b1 ();
    pipeline_stage_buf_if #(.CTRL_W(8), .DATA_W(101), .CNT_W(4))  b2 ();

    pipeline_stage_buf #(.CTRL_W(8), .DATA_W(101), .SKID(1), .CNT_W(16)) d0 (.clk(clk), .reset_n(reset_n), .bus(b0));
    pipeline_stage_buf #(.CTRL_W(8), .DATA_W(101), .SKID(0), .CNT_W(16)) d1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    pipeline_stage_buf #(.CTRL_W(8), .DATA_W(101), .SKID(1), .CNT_W(4))  d2 (.clk(clk), .reset_n(reset_n), .bus(b2));

    assign b0.in_valid = s_iv;  assign b1.in_valid = s_iv;  assign b2.in_valid = s_iv;
    assign b0.in_ctrl = s_ic;   assign b1.in_ctrl = s_ic;   assign b2.in_ctrl = s_ic;
    assign b0.in_data = s_id;   assign b1.in_data = s_id;   assign b2.in_data = s_id;
    assign b0.flush = s_fl;     assign b1.flush = s_fl;     assign b2.flush = s_fl;
    assign b0.out_ready = s_or; assign b1.out_ready = s_or; assign b2.out_ready = s_or;

    logic ir_a[3], ov_a[3];
    logic [7:0] oc_a[3];
    logic [100:0] od_a[3];
    logic [15:0] st_a[3];
    assign ir_a[0] = b0.in_ready;  assign ir_a[1] = b1.in_ready;  assign ir_a[2] = b2.in_ready;
    assign ov_a[0] = b0.out_valid; assign ov_a[1] = b1.out_valid; assign ov_a[2] = b2.out_valid;
    assign oc_a[0] = b0.out_ctrl;  assign oc_a[1] = b1.out_ctrl;  assign oc_a[2] = b2.out_ctrl;
    assign od_a[0] = b0.out_data;  assign od_a[1] = b1.out_data;  assign od_a[2] = b2.out_data;
    assign st_a[0] = b0.stall_cnt; assign st_a[1] = b1.stall_cnt; assign st_a[2] = 16'(b2.stall_cnt);

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_fail = 0;

    // Model: each variant is a FIFO of at most 2 (skid) or 1 (no skid) entries plus a saturating counter.
    bit sk[3] = '{1, 0, 1};
    int mx[3] = '{65535, 65535, 15};
    logic [7:0] mc[3][2];
    logic [100:0] md[3][2];
    int mn[3];
    int mcnt[3];

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d] got %0h want %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic logic [100:0] mk(input int n);
        return {37'(n), 32'(n) ^ 32'h5a5a0000, 32'(n)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mn[k] = 0;
            mcnt[k] = 0;
        end
    endtask

    task automatic tick(input bit iv, input logic [7:0] ic, input logic [100:0] id, input bit fl, input bit ordy);
        bit eir, eov;
        s_iv = iv; s_ic = ic; s_id = id; s_fl = fl; s_or = ordy;
        #1;
        for (int k = 0; k < 3; k++) begin
            eov = mn[k] > 0;
            eir = sk[k] ? (mn[k] < 2) : (ordy || mn[k] == 0);
            chk("in_ready", k, 128'(ir_a[k]), 128'(eir));
            chk("out_valid", k, 128'(ov_a[k]), 128'(eov));
            chk("out_ctrl", k, 128'(oc_a[k]), eov ? 128'(mc[k][0]) : 128'(0));
            if (eov) chk("out_data", k, 128'(od_a[k]), 128'(md[k][0]));
            chk("stall_cnt", k, 128'(st_a[k]), 128'(mcnt[k]));
            if (eov && !ordy && mcnt[k] < mx[k]) mcnt[k]++;
            if (fl) mn[k] = 0;
            else begin
                if (eov && ordy) begin
                    mc[k][0] = mc[k][1];
                    md[k][0] = md[k][1];
                    mn[k]--;
                end
                if (iv && eir) begin
                    mc[k][mn[k]] = ic;
                    md[k][mn[k]] = id;
                    mn[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit iv; logic [7:0] ic; int n; bit fl; bit ordy;
        bit ev; logic [7:0] ec; int en; bit eir; bit c1;
    } vec_t;
    vec_t tv[18];

    initial begin
        tv[0]  = '{1, 8'h41, 1, 0, 1,   1, 8'h41, 1, 1, 1};
        tv[1]  = '{1, 8'h42, 2, 0, 1,   1, 8'h42, 2, 1, 1};
        tv[2]  = '{1, 8'h43, 3, 0, 1,   1, 8'h43, 3, 1, 1};
        tv[3]  = '{1, 8'h44, 4, 0, 1,   1, 8'h44, 4, 1, 1};
        tv[4]  = '{0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 1, 1};
        tv[5]  = '{1, 8'h45, 5, 0, 0,   1, 8'h45, 5, 1, 0};
        tv[6]  = '{1, 8'h46, 6, 0, 0,   1, 8'h45, 5, 0, 0};
        tv[7]  = '{1, 8'h47, 7, 0, 0,   1, 8'h45, 5, 0, 0};
        tv[8]  = '{1, 8'h47, 7, 0, 1,   1, 8'h46, 6, 1, 0};
        tv[9]  = '{1, 8'h47, 7, 0, 1,   1, 8'h47, 7, 1, 0};
        tv[10] = '{0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 1, 0};
        tv[11] = '{1, 8'h48, 8, 0, 0,   1, 8'h48, 8, 1, 0};
        tv[12] = '{1, 8'h49, 9, 0, 0,   1, 8'h48, 8, 0, 0};
        tv[13] = '{1, 8'h4a, 10, 1, 0,  0, 8'h00, 0, 1, 0};
        tv[14] = '{0, 8'h00, 0, 0, 1,   0, 8'h00, 0, 1, 0};
        tv[15] = '{0, 8'hff, 0, 0, 1,   0, 8'h00, 0, 1, 0};
        tv[16] = '{1, 8'ha5, 85, 0, 1,  1, 8'ha5, 85, 1, 0};
        tv[17] = '{0, 8'hff, 0, 0, 1,   0, 8'h00, 0, 1, 0};

        reset_n = 0;
        s_iv = 0; s_ic = 0; s_id = 0; s_fl = 0; s_or = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_valid", k, 128'(ov_a[k]), 128'(0));
            chk("rst_ctrl", k, 128'(oc_a[k]), 128'(0));
            chk("rst_data", k, 128'(od_a[k]), 128'(0));
            chk("rst_stall", k, 128'(st_a[k]), 128'(0));
            chk("rst_ready", k, 128'(ir_a[k]), 128'(1));
        end
        reset_n = 1;

        for (int i = 0; i < 18; i++) begin
            tick(tv[i].iv, tv[i].ic, mk(tv[i].n), tv[i].fl, tv[i].ordy);
            chk("vec_valid", i, 128'(ov_a[0]), 128'(tv[i].ev));
            chk("vec_ctrl", i, 128'(oc_a[0]), 128'(tv[i].ec));
            chk("vec_ready", i, 128'(ir_a[0]), 128'(tv[i].eir));
            if (tv[i].ev) chk("vec_data", i, 128'(od_a[0]), 128'(mk(tv[i].en)));
            if (tv[i].c1) begin
                chk("vec_noskid_valid", i, 128'(ov_a[1]), 128'(tv[i].ev));
                chk("vec_noskid_ctrl", i, 128'(oc_a[1]), 128'(tv[i].ec));
                if (tv[i].ev) chk("vec_noskid_data", i, 128'(od_a[1]), 128'(mk(tv[i].en)));
            end
        end

        repeat (3) tick(1, 8'h11, {5'h11, {12{8'h11}}}, 0, 0);
        #2;
        s_iv = 0;
        reset_n = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("arst_valid", k, 128'(ov_a[k]), 128'(0));
            chk("arst_ctrl", k, 128'(oc_a[k]), 128'(0));
            chk("arst_data", k, 128'(od_a[k]), 128'(0));
            chk("arst_stall", k, 128'(st_a[k]), 128'(0));
            chk("arst_ready", k, 128'(ir_a[k]), 128'(1));
        end
        model_reset();
        #2;
        reset_n = 1;
        @(posedge clk);
        #1;

        tick(1, 8'h3c, mk(60), 0, 0);
        repeat (20) tick(0, 8'h00, '0, 0, 0);
        chk("sat_cnt4", 2, 128'(st_a[2]), 128'(15));
        chk("sat_cnt16", 0, 128'(st_a[0]), 128'(20));
        tick(0, 8'h00, '0, 0, 0);
        chk("sat_hold", 2, 128'(st_a[2]), 128'(15));

        tick(0, 8'h00, '0, 1, 1);
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 1) == 1, 8'($urandom), {5'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)},
                 $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
